mem_dump_engine: RTL and testbench

- Hardware replacement for the bench-side memory dump performed after a program finishes (e.g. fibonacci results).
- Sits downstream of the DA_VINCI memory and shares its ADDR/READ/WRITE/data bus while the processor is halted.
- Walks an inclusive word-address range, reads each word and streams (address, data) pairs out on a valid/ready port.
- Intended consumers are a trace/UART sink or the testbench checker.

---
 rtl/mem_dump_engine_pkg.sv | 24 ++
 rtl/mem_dump_addr_gen.sv | 57 +++++
 rtl/mem_dump_engine.sv | 152 +++++++++++++++
 tb/tb_mem_dump_engine.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dump_engine_pkg.sv
// Shared definitions for the memory dump engine: default bus widths,
// FSM state encoding and the read-latency timer width.
package mem_dump_engine_pkg;

   localparam int ADDRESS_INDEX_LIMIT = 25;
   localparam int DATA_INDEX_LIMIT    = 31;
   localparam int ADDR_W_DEF          = ADDRESS_INDEX_LIMIT + 1;
   localparam int DATA_W_DEF          = DATA_INDEX_LIMIT + 1;

   // Read latency is limited to 1..15, so a 4-bit down-counter suffices.
   localparam int LAT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_PRESENT = 2'd2,
      ST_FINISH  = 2'd3
   } dump_state_e;

   function automatic logic [LAT_W-1:0] lat_init(input int rd_latency);
      return LAT_W'(rd_latency - 1);
   endfunction

endpackage

// File: rtl/mem_dump_addr_gen.sv
// Address walker for the dump engine: latched end address, current word
// pointer, last-word detect and the accepted-word counter.
module mem_dump_addr_gen #(
   parameter int ADDR_W = 26
) (
   input  logic              clk_sys,
   input  logic              rst_b,
   input  logic              load,
   input  logic              advance,
   input  logic              count,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   output logic [ADDR_W-1:0] cur_addr,
   output logic              last_word,
   output logic [ADDR_W:0]   word_cnt
);

   logic [ADDR_W-1:0] cur_q, cur_d;
   logic [ADDR_W-1:0] end_q, end_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;

   always_comb begin
      cur_d = cur_q;
      end_d = end_q;
      cnt_d = cnt_q;
      if (load) begin
         cur_d = start_addr;
         end_d = end_addr;
         cnt_d = '0;
      end else begin
         if (count) begin
            cnt_d = cnt_q + (ADDR_W+1)'(1);
         end
         // advance is only asserted when last_word is low, so cur never wraps
         if (advance) begin
            cur_d = cur_q + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         cur_q <= '0;
         end_q <= '0;
         cnt_q <= '0;
      end else begin
         cur_q <= cur_d;
         end_q <= end_d;
         cnt_q <= cnt_d;
      end
   end

   assign cur_addr  = cur_q;
   assign last_word = (cur_q == end_q);
   assign word_cnt  = cnt_q;

endmodule

// File: rtl/mem_dump_engine.sv
// Walks an inclusive word range on the halted memory bus and streams
// (address, data) pairs on a valid/ready port.
//
//   state   | meaning
//   IDLE    | waiting for START; rejects inverted ranges with ERR
//   ISSUE   | READ held for RD_LATENCY cycles at cur, data captured at the end
//   PRESENT | pair held on OUT_* until OUT_READY
//   FINISH  | one-cycle DONE, then back to IDLE
module mem_dump_engine
   import mem_dump_engine_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int RD_LATENCY = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic              ABORT,
   input  logic [ADDR_W-1:0] START_ADDR,
   input  logic [ADDR_W-1:0] END_ADDR,
   output logic [ADDR_W-1:0] ADDR,
   output logic              READ,
   output logic              WRITE,
   input  logic [DATA_W-1:0] MEM_DATA_IN,
   output logic [ADDR_W-1:0] OUT_ADDR,
   output logic [DATA_W-1:0] OUT_DATA,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR,
   output logic [ADDR_W:0]   WORD_CNT
);

   localparam logic [LAT_W-1:0] LAT_LOAD = lat_init(RD_LATENCY);

   dump_state_e       state_q, state_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              err_q, err_d;

   logic              load;
   logic              handshake;
   logic              advance;
   logic [ADDR_W-1:0] cur_addr;
   logic              last_word;

   mem_dump_addr_gen #(
      .ADDR_W(ADDR_W)
   ) u_addr_gen (
      .clk_sys    (CLK),
      .rst_b      (RST),
      .load       (load),
      .advance    (advance),
      .count      (handshake),
      .start_addr (START_ADDR),
      .end_addr   (END_ADDR),
      .cur_addr   (cur_addr),
      .last_word  (last_word),
      .word_cnt   (WORD_CNT)
   );

   always_comb begin
      state_d    = state_q;
      lat_d      = lat_q;
      out_addr_d = out_addr_q;
      out_data_d = out_data_q;
      err_d      = 1'b0;
      load       = 1'b0;
      handshake  = 1'b0;
      advance    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (START && !ABORT) begin
               if (START_ADDR <= END_ADDR) begin
                  load    = 1'b1;
                  lat_d   = LAT_LOAD;
                  state_d = ST_ISSUE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            if (lat_q == '0) begin
               out_addr_d = cur_addr;
               out_data_d = MEM_DATA_IN;
               state_d    = ST_PRESENT;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         ST_PRESENT: begin
            if (OUT_READY) begin
               handshake = 1'b1;
               if (last_word) begin
                  state_d = ST_FINISH;
               end else begin
                  advance = 1'b1;
                  lat_d   = LAT_LOAD;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort overrides whatever the current state decided this cycle.
      if (ABORT && (state_q != ST_IDLE)) begin
         state_d    = ST_IDLE;
         handshake  = 1'b0;
         advance    = 1'b0;
         out_addr_d = out_addr_q;
         out_data_d = out_data_q;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= ST_IDLE;
         lat_q      <= '0;
         out_addr_q <= '0;
         out_data_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         lat_q      <= lat_d;
         out_addr_q <= out_addr_d;
         out_data_q <= out_data_d;
         err_q      <= err_d;
      end
   end

   assign ADDR      = cur_addr;
   assign READ      = (state_q == ST_ISSUE);
   assign WRITE     = 1'b0;
   assign OUT_ADDR  = out_addr_q;
   assign OUT_DATA  = out_data_q;
   assign OUT_VALID = (state_q == ST_PRESENT);
   assign BUSY      = (state_q != ST_IDLE);
   assign DONE      = (state_q == ST_FINISH);
   assign ERR       = err_q;

endmodule

// File: tb/tb_mem_dump_engine.sv
// Directed bench for mem_dump_engine: one instance at RD_LATENCY=1 and one at
// RD_LATENCY=3, both on a behavioural memory with a preloaded fibonacci region.
module tb_mem_dump_engine;

   localparam int AW = 26;
   localparam int DW = 32;

   localparam logic [31:0] FIB [16] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13,
                                        32'd21, 32'd34, 32'd55, 32'd89, 32'd144, 32'd233,
                                        32'd377, 32'd610};

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start [2];
   logic          abort;
   logic [AW-1:0] sa, ea;
   logic          out_ready;

   logic [AW-1:0] addr [2];
   logic [AW-1:0] out_addr [2];
   logic [DW-1:0] mem_din [2];
   logic [DW-1:0] out_data [2];
   logic          read [2], write [2], out_valid [2], busy [2], done [2], err [2];
   logic [AW:0]   word_cnt [2];

   int n_checks = 0;
   int n_errs   = 0;
   int cyc      = 0;

   logic [AW-1:0] exp_addr [2], last_addr [2], hold_a [2];
   logic [DW-1:0] hold_d [2];
   logic          held [2];
   int n_hs [2], n_done [2], n_err [2], stab_err [2], bad_rd [2];
   int n_stall [2], zero_acc [2], n_wr [2], done_cyc [2], start_cyc [2];

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
      if (a >= 26'h1000000 && a <= 26'h100000F) return FIB[a[3:0]];
      return {6'h2A, a};
   endfunction

   assign mem_din[0] = mem_f(addr[0]);
   assign mem_din[1] = mem_f(addr[1]);

   mem_dump_engine #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) u_dut_l1 (
      .CLK(clk), .RST(rst_n), .START(start[0]), .ABORT(abort),
      .START_ADDR(sa), .END_ADDR(ea), .ADDR(addr[0]), .READ(read[0]), .WRITE(write[0]),
      .MEM_DATA_IN(mem_din[0]), .OUT_ADDR(out_addr[0]), .OUT_DATA(out_data[0]),
      .OUT_VALID(out_valid[0]), .OUT_READY(out_ready), .BUSY(busy[0]), .DONE(done[0]),
      .ERR(err[0]), .WORD_CNT(word_cnt[0]));

   mem_dump_engine #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3)) u_dut_l3 (
      .CLK(clk), .RST(rst_n), .START(start[1]), .ABORT(abort),
      .START_ADDR(sa), .END_ADDR(ea), .ADDR(addr[1]), .READ(read[1]), .WRITE(write[1]),
      .MEM_DATA_IN(mem_din[1]), .OUT_ADDR(out_addr[1]), .OUT_DATA(out_data[1]),
      .OUT_VALID(out_valid[1]), .OUT_READY(out_ready), .BUSY(busy[1]), .DONE(done[1]),
      .ERR(err[1]), .WORD_CNT(word_cnt[1]));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic clr(input int i, input logic [AW-1:0] base);
      exp_addr[i] = base;
      last_addr[i] = '0;
      held[i] = 1'b0;
      n_hs[i] = 0; n_done[i] = 0; n_err[i] = 0; stab_err[i] = 0; bad_rd[i] = 0;
      n_stall[i] = 0; zero_acc[i] = 0; n_wr[i] = 0; done_cyc[i] = 0;
   endtask

   // Inputs for the coming edge are already driven when this runs.
   task automatic sample();
      for (int i = 0; i < 2; i++) begin
         if (write[i]) n_wr[i]++;
         if (read[i] && addr[i] == '0) zero_acc[i]++;
         if (done[i]) begin n_done[i]++; done_cyc[i] = cyc; end
         if (err[i]) n_err[i]++;
         if (out_valid[i]) begin
            if (read[i]) bad_rd[i]++;
            if (held[i]) begin
               n_stall[i]++;
               if (out_addr[i] !== hold_a[i] || out_data[i] !== hold_d[i]) stab_err[i]++;
            end
            held[i] = !out_ready;
            hold_a[i] = out_addr[i];
            hold_d[i] = out_data[i];
            if (out_ready) begin
               check("hs_addr", 64'(out_addr[i]), 64'(exp_addr[i]));
               check("hs_data", 64'(out_data[i]), 64'(mem_f(exp_addr[i])));
               last_addr[i] = out_addr[i];
               exp_addr[i] = exp_addr[i] + 1'b1;
               n_hs[i]++;
            end
         end else begin
            held[i] = 1'b0;
         end
      end
   endtask

   // Called at a falling edge after inputs are driven; returns at the next one.
   task automatic step();
      #1;
      sample();
      @(negedge clk);
      cyc++;
   endtask

   task automatic start_dump(input int i);
      start[i] = 1'b1;
      start_cyc[i] = cyc + 1;
      step();
      start[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input int budget);
      int k = 0;
      while (!(n_done[i] != 0 && !busy[i]) && k < budget) begin
         step();
         k++;
      end
      check("done_timeout", 64'(k < budget), 64'd1);
   endtask

   initial begin
      int k;
      logic [3:0] pat;
      rst_n = 1'b0; abort = 1'b0; start[0] = 1'b0; start[1] = 1'b0;
      sa = '0; ea = '0; out_ready = 1'b0;
      clr(0, '0); clr(1, '0);
      repeat (2) @(negedge clk);

      // reset state
      check("rst_busy",     64'(busy[0]),      64'd0);
      check("rst_read",     64'(read[0]),      64'd0);
      check("rst_write",    64'(write[0]),     64'd0);
      check("rst_valid",    64'(out_valid[0]), 64'd0);
      check("rst_done",     64'(done[0]),      64'd0);
      check("rst_err",      64'(err[0]),       64'd0);
      check("rst_addr",     64'(addr[0]),      64'd0);
      check("rst_out_addr", 64'(out_addr[0]),  64'd0);
      check("rst_out_data", 64'(out_data[0]),  64'd0);
      check("rst_word_cnt", 64'(word_cnt[0]),  64'd0);
      rst_n = 1'b1;
      step(); step();
      check("idle_after_rst", 64'(busy[0]), 64'd0);

      // fibonacci region, RD_LATENCY=1
      clr(0, 26'h1000000);
      sa = 26'h1000000; ea = 26'h100000F; out_ready = 1'b1;
      start_dump(0);
      wait_done(0, 100);
      check("fib_words",    64'(n_hs[0]),                      64'd16);
      check("fib_last",     64'(last_addr[0]),                 64'h100000F);
      check("fib_done",     64'(n_done[0]),                    64'd1);
      check("fib_word_cnt", 64'(word_cnt[0]),                  64'd16);
      check("fib_cycles",   64'(done_cyc[0] - start_cyc[0]),   64'd32);
      check("fib_err",      64'(n_err[0]),                     64'd0);
      check("fib_write",    64'(n_wr[0]),                      64'd0);

      // top of memory, RD_LATENCY=3
      clr(1, 26'h3FFFFF0);
      sa = 26'h3FFFFF0; ea = 26'h3FFFFFF;
      start_dump(1);
      wait_done(1, 200);
      check("top_words",    64'(n_hs[1]),                      64'd16);
      check("top_last",     64'(last_addr[1]),                 64'h3FFFFFF);
      check("top_zero_acc", 64'(zero_acc[1]),                  64'd0);
      check("top_done",     64'(n_done[1]),                    64'd1);
      check("top_word_cnt", 64'(word_cnt[1]),                  64'd16);
      check("top_cycles",   64'(done_cyc[1] - start_cyc[1]),   64'd64);

      // backpressure 1-0-0-1 on a 4-word dump
      clr(0, 26'h20);
      sa = 26'h20; ea = 26'h23; pat = 4'b1001;
      k = 0;
      out_ready = pat[0];
      start_dump(0);
      k = 1;
      while (!(n_done[0] != 0 && !busy[0]) && k < 100) begin
         out_ready = pat[k % 4];
         step();
         k++;
      end
      check("bp_timeout",  64'(k < 100),      64'd1);
      check("bp_words",    64'(n_hs[0]),      64'd4);
      check("bp_stalled",  64'(n_stall[0] > 0), 64'd1);
      check("bp_stable",   64'(stab_err[0]),  64'd0);
      check("bp_no_read",  64'(bad_rd[0]),    64'd0);
      check("bp_word_cnt", 64'(word_cnt[0]),  64'd4);
      check("bp_done",     64'(n_done[0]),    64'd1);

      // inverted range is rejected
      clr(0, '0);
      out_ready = 1'b1;
      sa = 26'h10; ea = 26'h0F;
      start_dump(0);
      check("err_busy",    64'(busy[0]),      64'd0);
      check("err_pulse",   64'(err[0]),       64'd1);
      step(); step();
      check("err_count",   64'(n_err[0]),     64'd1);
      check("err_busy2",   64'(busy[0]),      64'd0);
      check("err_cnt_kept", 64'(word_cnt[0]), 64'd4);

      // START while busy is ignored and the new range is not taken
      clr(0, 26'h40);
      sa = 26'h40; ea = 26'h43;
      start_dump(0);
      step(); step();
      sa = 26'h80; ea = 26'h80;
      start_dump(0);
      wait_done(0, 100);
      check("ign_words",    64'(n_hs[0]),     64'd4);
      check("ign_last",     64'(last_addr[0]), 64'h43);
      check("ign_err",      64'(n_err[0]),    64'd0);
      check("ign_word_cnt", 64'(word_cnt[0]), 64'd4);

      // abort after 5 accepted words
      clr(0, 26'h1000000);
      sa = 26'h1000000; ea = 26'h100000F;
      start_dump(0);
      k = 0;
      while (n_hs[0] < 5 && k < 100) begin step(); k++; end
      check("ab_timeout", 64'(k < 100), 64'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("ab_busy",     64'(busy[0]),      64'd0);
      check("ab_read",     64'(read[0]),      64'd0);
      check("ab_valid",    64'(out_valid[0]), 64'd0);
      check("ab_word_cnt", 64'(word_cnt[0]),  64'd5);
      step(); step(); step();
      check("ab_no_done",  64'(n_done[0]),    64'd0);
      check("ab_cnt_kept", 64'(word_cnt[0]),  64'd5);
      clr(0, 26'h1000000);
      ea = 26'h1000003;
      start_dump(0);
      wait_done(0, 100);
      check("rs_words",    64'(n_hs[0]),      64'd4);
      check("rs_word_cnt", 64'(word_cnt[0]),  64'd4);
      check("rs_done",     64'(n_done[0]),    64'd1);

      // START together with ABORT in IDLE
      clr(0, '0);
      sa = 26'h0; ea = 26'h3;
      abort = 1'b1;
      start_dump(0);
      abort = 1'b0;
      step();
      check("sa_busy", 64'(busy[0]),  64'd0);
      check("sa_err",  64'(n_err[0]), 64'd0);

      // asynchronous reset while stalled in PRESENT
      clr(0, 26'h50);
      sa = 26'h50; ea = 26'h5F;
      start_dump(0);
      k = 0;
      while (n_hs[0] < 2 && k < 100) begin step(); k++; end
      out_ready = 1'b0;
      while (!out_valid[0] && k < 100) begin step(); k++; end
      check("ar_reach", 64'(k < 100), 64'd1);
      check("ar_pre_cnt", 64'(word_cnt[0]), 64'd2);
      #3 rst_n = 1'b0;
      #1;
      check("ar_read",     64'(read[0]),      64'd0);
      check("ar_valid",    64'(out_valid[0]), 64'd0);
      check("ar_busy",     64'(busy[0]),      64'd0);
      check("ar_word_cnt", 64'(word_cnt[0]),  64'd0);
      @(negedge clk);
      cyc++;
      rst_n = 1'b1;
      out_ready = 1'b1;
      step(); step();
      check("ar_idle",     64'(busy[0]),      64'd0);
      check("ar_idle_rd",  64'(read[0]),      64'd0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
